// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp patterns, monitor states, fault codes and defaults
package traffic_pkg;

  localparam int YEL_MIN_DEF    = 2;
  localparam int YEL_MAX_DEF    = 8;
  localparam int FLASH_HALF_DEF = 4;

  // Lamp vector order is {Ra, Ga, Ya, Rb, Gb, Yb}
  localparam logic [5:0] PAT_A_GO  = 6'b010_100;
  localparam logic [5:0] PAT_A_YEL = 6'b001_100;
  localparam logic [5:0] PAT_B_GO  = 6'b100_010;
  localparam logic [5:0] PAT_B_YEL = 6'b100_001;
  localparam logic [5:0] PAT_ALL_RED = 6'b100_100;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_A_GO  = 3'd1,
    ST_A_YEL = 3'd2,
    ST_B_GO  = 3'd3,
    ST_B_YEL = 3'd4,
    ST_FAULT = 3'd5
  } mon_state_t;

  typedef enum logic [2:0] {
    FC_NONE       = 3'd0,
    FC_LAMP       = 3'd1,
    FC_CONFLICT   = 3'd2,
    FC_TRANSITION = 3'd3,
    FC_YEL_SHORT  = 3'd4,
    FC_YEL_LONG   = 3'd5
  } fault_code_t;

  function automatic mon_state_t next_phase(input mon_state_t s);
    case (s)
      ST_A_GO:  return ST_A_YEL;
      ST_A_YEL: return ST_B_GO;
      ST_B_GO:  return ST_B_YEL;
      ST_B_YEL: return ST_A_GO;
      default:  return ST_INIT;
    endcase
  endfunction

endpackage

// File: rtl/signal_pattern_decoder.sv
// rtl/signal_pattern_decoder.sv - classifies the six lamp drives into a legal phase or an error
module signal_pattern_decoder
  import traffic_pkg::*;
(
  input  logic       ra_i,
  input  logic       ga_i,
  input  logic       ya_i,
  input  logic       rb_i,
  input  logic       gb_i,
  input  logic       yb_i,
  output mon_state_t pat_state_o,
  output logic       lamp_err_o,
  output logic       conflict_err_o
);

  logic [5:0] lamps;
  logic       a_one;
  logic       b_one;

  assign lamps = {ra_i, ga_i, ya_i, rb_i, gb_i, yb_i};
  assign a_one = (ra_i ^ ga_i ^ ya_i) & ~(ra_i & ga_i & ya_i);
  assign b_one = (rb_i ^ gb_i ^ yb_i) & ~(rb_i & gb_i & yb_i);

  // All-red has one lamp per direction but is not a phase the controller may show
  assign lamp_err_o     = ~(a_one & b_one) | (lamps == PAT_ALL_RED);
  assign conflict_err_o = (ga_i | ya_i) & (gb_i | yb_i);

  always_comb begin
    pat_state_o = ST_INIT;
    case (lamps)
      PAT_A_GO:  pat_state_o = ST_A_GO;
      PAT_A_YEL: pat_state_o = ST_A_YEL;
      PAT_B_GO:  pat_state_o = ST_B_GO;
      PAT_B_YEL: pat_state_o = ST_B_YEL;
      default:   pat_state_o = ST_INIT;
    endcase
  end

endmodule

// File: rtl/signal_conflict_monitor.sv
// rtl/signal_conflict_monitor.sv - lamp-sequence monitor with latched fault code and flashing red
module signal_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int YEL_MIN    = YEL_MIN_DEF,
  parameter int YEL_MAX    = YEL_MAX_DEF,
  parameter int FLASH_HALF = FLASH_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ra,
  input  logic       Ga,
  input  logic       Ya,
  input  logic       Rb,
  input  logic       Gb,
  input  logic       Yb,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic [7:0] cycles,
  output logic [2:0] mon_state
);

  localparam logic [7:0] YEL_MIN_C  = 8'(YEL_MIN);
  localparam logic [7:0] YEL_MAX_C  = 8'(YEL_MAX);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);

  mon_state_t  state_q, state_d;
  fault_code_t code_q, code_d;
  fault_code_t viol;
  logic        fault_q, fault_d;
  logic        flash_q, flash_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [7:0]  cycles_q, cycles_d;
  logic [7:0]  dwell_inc;
  logic        in_yellow;

  mon_state_t  pat_state;
  logic        lamp_err;
  logic        conflict_err;

  signal_pattern_decoder u_decoder (
    .ra_i           (Ra),
    .ga_i           (Ga),
    .ya_i           (Ya),
    .rb_i           (Rb),
    .gb_i           (Gb),
    .yb_i           (Yb),
    .pat_state_o    (pat_state),
    .lamp_err_o     (lamp_err),
    .conflict_err_o (conflict_err)
  );

  assign dwell_inc = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
  assign in_yellow = (state_q == ST_A_YEL) || (state_q == ST_B_YEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      code_q   <= FC_NONE;
      fault_q  <= 1'b0;
      flash_q  <= 1'b0;
      dwell_q  <= 8'd0;
      fcnt_q   <= 8'd0;
      cycles_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      fault_q  <= fault_d;
      flash_q  <= flash_d;
      dwell_q  <= dwell_d;
      fcnt_q   <= fcnt_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    fault_d  = fault_q;
    flash_d  = flash_q;
    dwell_d  = dwell_q;
    fcnt_d   = fcnt_q;
    cycles_d = cycles_q;
    viol     = FC_NONE;

    case (state_q)
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_INIT;
          code_d  = FC_NONE;
          fault_d = 1'b0;
          flash_d = 1'b0;
          fcnt_d  = 8'd0;
          dwell_d = 8'd0;
        end else begin
          dwell_d = dwell_inc;
          if (fcnt_q == FLASH_LAST) begin
            flash_d = ~flash_q;
            fcnt_d  = 8'd0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      ST_INIT: begin
        if (lamp_err)          viol = FC_LAMP;
        else if (conflict_err) viol = FC_CONFLICT;
        else begin
          state_d = pat_state;
          dwell_d = 8'd1;
        end
      end
      default: begin
        if (lamp_err)          viol = FC_LAMP;
        else if (conflict_err) viol = FC_CONFLICT;
        else if (pat_state == state_q) begin
          // Holding yellow is illegal once the next dwell value would pass YEL_MAX
          if (in_yellow && dwell_q >= YEL_MAX_C) viol = FC_YEL_LONG;
          else                                   dwell_d = dwell_inc;
        end else if (pat_state == next_phase(state_q)) begin
          if (in_yellow && dwell_q < YEL_MIN_C) viol = FC_YEL_SHORT;
          else begin
            state_d = pat_state;
            dwell_d = 8'd1;
            if (state_q == ST_B_YEL) cycles_d = cycles_q + 8'd1;
          end
        end else begin
          viol = FC_TRANSITION;
        end
      end
    endcase

    if (viol != FC_NONE) begin
      state_d = ST_FAULT;
      code_d  = viol;
      fault_d = 1'b1;
      flash_d = 1'b1;
      fcnt_d  = 8'd0;
      dwell_d = 8'd1;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign flash      = flash_q;
  assign cycles     = cycles_q;
  assign mon_state  = state_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// tb/tb_signal_conflict_monitor.sv - directed self-checking bench for signal_conflict_monitor
module tb_signal_conflict_monitor;

  localparam logic [5:0] P_A_GO  = 6'b010_100;
  localparam logic [5:0] P_A_YEL = 6'b001_100;
  localparam logic [5:0] P_B_GO  = 6'b100_010;
  localparam logic [5:0] P_B_YEL = 6'b100_001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Ra = 1'b0, Ga = 1'b0, Ya = 1'b0, Rb = 1'b0, Gb = 1'b0, Yb = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [7:0] cycles;
  logic [2:0] mon_state;

  int n_checks = 0;
  int n_fail = 0;
  int fault_seen = 0;

  signal_conflict_monitor #(.YEL_MIN(2), .YEL_MAX(8), .FLASH_HALF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Ra         (Ra),
    .Ga         (Ga),
    .Ya         (Ya),
    .Rb         (Rb),
    .Gb         (Gb),
    .Yb         (Yb),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash      (flash),
    .cycles     (cycles),
    .mon_state  (mon_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] p, input int n);
    {Ra, Ga, Ya, Rb, Gb, Yb} = p;
    for (int i = 0; i < n; i++) begin
      tick();
      if (fault) fault_seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fault_clr = 1'b0;
    {Ra, Ga, Ya, Rb, Gb, Yb} = P_A_GO;
    tick();
    rst = 1'b0;
    fault_seen = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {Ra, Ga, Ya, Rb, Gb, Yb} = 6'b111_111;
    tick();
    n_checks++; if (mon_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", mon_state); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0d expected 0", fault); end
    n_checks++; if (fault_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", fault_code); end
    n_checks++; if (flash !== 1'b0) begin n_fail++; $display("FAIL reset_flash: got %0d expected 0", flash); end
    n_checks++; if (cycles !== 8'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
    rst = 1'b0;
  endtask

  task automatic test_legal_sequence();
    do_reset();
    drive(P_A_GO, 5);
    n_checks++; if (mon_state !== 3'd1) begin n_fail++; $display("FAIL seq_a_go: got %0d expected 1", mon_state); end
    drive(P_A_YEL, 3);
    n_checks++; if (mon_state !== 3'd2) begin n_fail++; $display("FAIL seq_a_yel: got %0d expected 2", mon_state); end
    drive(P_B_GO, 4);
    n_checks++; if (mon_state !== 3'd3) begin n_fail++; $display("FAIL seq_b_go: got %0d expected 3", mon_state); end
    drive(P_B_YEL, 3);
    n_checks++; if (mon_state !== 3'd4) begin n_fail++; $display("FAIL seq_b_yel: got %0d expected 4", mon_state); end
    n_checks++; if (cycles !== 8'd0) begin n_fail++; $display("FAIL seq_cycles_pre: got %0d expected 0", cycles); end
    drive(P_A_GO, 1);
    n_checks++; if (mon_state !== 3'd1) begin n_fail++; $display("FAIL seq_wrap_state: got %0d expected 1", mon_state); end
    n_checks++; if (cycles !== 8'd1) begin n_fail++; $display("FAIL seq_cycles: got %0d expected 1", cycles); end
    n_checks++; if (fault_seen !== 0) begin n_fail++; $display("FAIL seq_no_fault: got %0d fault cycles expected 0", fault_seen); end
  endtask

  task automatic test_conflict_flash();
    logic [7:0] exp_flash;
    exp_flash = 8'b1000_0111;
    do_reset();
    drive(P_A_GO, 2);
    drive(P_A_YEL, 2);
    drive(P_B_GO, 2);
    drive(6'b010_010, 1);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL conflict_fault: got %0d expected 1", fault); end
    n_checks++; if (fault_code !== 3'd2) begin n_fail++; $display("FAIL conflict_code: got %0d expected 2", fault_code); end
    n_checks++; if (flash !== 1'b1) begin n_fail++; $display("FAIL conflict_flash_entry: got %0d expected 1", flash); end
    n_checks++; if (mon_state !== 3'd5) begin n_fail++; $display("FAIL conflict_state: got %0d expected 5", mon_state); end
    for (int k = 1; k <= 8; k++) begin
      drive((k > 4) ? 6'b111_111 : 6'b010_010, 1);
      n_checks++;
      if (flash !== exp_flash[k-1]) begin
        n_fail++; $display("FAIL flash_toggle_%0d: got %0d expected %0d", k, flash, exp_flash[k-1]);
      end
    end
    n_checks++; if (fault_code !== 3'd2) begin n_fail++; $display("FAIL code_latched: got %0d expected 2", fault_code); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(P_A_GO, 2);
    drive(6'b110_010, 1);
    n_checks++; if (fault_code !== 3'd1) begin n_fail++; $display("FAIL priority_code: got %0d expected 1", fault_code); end
    do_reset();
    drive(P_A_GO, 2);
    drive(P_B_GO, 1);
    n_checks++; if (fault_code !== 3'd3) begin n_fail++; $display("FAIL transition_code: got %0d expected 3", fault_code); end
  endtask

  task automatic test_yellow_bounds();
    do_reset();
    drive(P_A_GO, 2);
    drive(P_A_YEL, 1);
    drive(P_B_GO, 1);
    n_checks++; if (fault_code !== 3'd4) begin n_fail++; $display("FAIL yel_short_code: got %0d expected 4", fault_code); end
    do_reset();
    drive(P_A_GO, 2);
    drive(P_A_YEL, 2);
    drive(P_B_GO, 1);
    n_checks++; if (fault !== 1'b0 || mon_state !== 3'd3) begin n_fail++; $display("FAIL yel_min_ok: got fault %0d state %0d expected 0 3", fault, mon_state); end
    do_reset();
    drive(P_A_GO, 2);
    drive(P_A_YEL, 8);
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL yel_max_ok: got %0d expected 0", fault); end
    drive(P_A_YEL, 1);
    n_checks++; if (fault_code !== 3'd5) begin n_fail++; $display("FAIL yel_long_code: got %0d expected 5", fault_code); end
  endtask

  task automatic test_fault_clr();
    do_reset();
    drive(P_A_GO, 2);
    fault_clr = 1'b1;
    drive(P_A_GO, 1);
    fault_clr = 1'b0;
    n_checks++; if (mon_state !== 3'd1) begin n_fail++; $display("FAIL clr_ignored: got %0d expected 1", mon_state); end
    drive(P_A_YEL, 2); drive(P_B_GO, 2); drive(P_B_YEL, 2); drive(P_A_GO, 1);
    drive(P_B_YEL, 1);
    n_checks++; if (fault_code !== 3'd3) begin n_fail++; $display("FAIL clr_setup_code: got %0d expected 3", fault_code); end
    fault_clr = 1'b1;
    drive(P_A_GO, 1);
    fault_clr = 1'b0;
    n_checks++; if (mon_state !== 3'd0) begin n_fail++; $display("FAIL clr_state: got %0d expected 0", mon_state); end
    n_checks++; if ({fault, fault_code, flash} !== 5'b0) begin n_fail++; $display("FAIL clr_outputs: got %0d/%0d/%0d expected 0/0/0", fault, fault_code, flash); end
    n_checks++; if (cycles !== 8'd1) begin n_fail++; $display("FAIL clr_cycles: got %0d expected 1", cycles); end
    drive(P_A_GO, 1);
    n_checks++; if (mon_state !== 3'd1 || fault !== 1'b0) begin n_fail++; $display("FAIL clr_resume: got state %0d fault %0d expected 1 0", mon_state, fault); end
    drive(P_B_YEL, 1);
    rst = 1'b1;
    fault_clr = 1'b1;
    drive(6'b111_111, 1);
    rst = 1'b0;
    fault_clr = 1'b0;
    n_checks++;
    if ({mon_state, fault, fault_code, flash, cycles} !== 16'd0) begin
      n_fail++; $display("FAIL rst_over_clr: got state %0d fault %0d code %0d flash %0d cycles %0d expected all 0", mon_state, fault, fault_code, flash, cycles);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(P_A_GO, 1);
    for (int c = 0; c < 255; c++) begin
      drive(P_A_YEL, 2); drive(P_B_GO, 1); drive(P_B_YEL, 2); drive(P_A_GO, 1);
    end
    n_checks++; if (cycles !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", cycles); end
    drive(P_A_YEL, 2); drive(P_B_GO, 1); drive(P_B_YEL, 2); drive(P_A_GO, 1);
    n_checks++; if (cycles !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", cycles); end
    n_checks++; if (fault_seen !== 0) begin n_fail++; $display("FAIL wrap_no_fault: got %0d fault cycles expected 0", fault_seen); end
  endtask

  initial begin
    test_reset();
    test_legal_sequence();
    test_conflict_flash();
    test_priority();
    test_yellow_bounds();
    test_fault_clr();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_conflict_monitor.md
SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 Parameter YEL_MIN, default 2: minimum legal yellow dwell, in clock cycles.
REQ-002 Parameter YEL_MAX, default 8: maximum legal yellow dwell, in clock cycles.
REQ-003 Parameter FLASH_HALF, default 4: half-period of the flash output, in cycles.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Ports Ra, Ga, Ya, input, 1 each: direction-A red, green and yellow lamp drives from the light controller.
REQ-007 Ports Rb, Gb, Yb, input, 1 each: direction-B red, green and yellow lamp drives.
REQ-008 Port fault_clr, input, 1: synchronous request to leave the FAULT state.
REQ-009 Port fault, output, 1: latched fault indication.
REQ-010 Port fault_code, output, 3: cause of the first fault (0 none, 1 lamp-combination, 2 conflict, 3 transition, 4 yellow-short, 5 yellow-long).
REQ-011 Port flash, output, 1: flashing-red drive, active only in FAULT.
REQ-012 Port cycles, output, 8: count of completed A/B phase cycles.
REQ-013 Port mon_state, output, 3: current monitor state encoding.

Function
REQ-014 The monitor SHALL sample the six lamp inputs at every rising edge, with no input register; each decision SHALL be visible on the outputs after that same edge (latency 1).
REQ-015 The four legal patterns SHALL be:
- A_GO = Ga,Rb
- A_YEL = Ya,Rb
- B_GO = Ra,Gb
- B_YEL = Ra,Yb
Exactly these two lamps are on; all other lamps are off.
REQ-016 States SHALL be INIT, A_GO, A_YEL, B_GO, B_YEL, FAULT.
REQ-017 INIT SHALL move to the state matching whichever legal pattern is sampled; any illegal pattern sampled in INIT SHALL go to FAULT.
REQ-018 Legal transitions SHALL be:
- each GO/YEL state to itself
- A_GO->A_YEL, A_YEL->B_GO, B_GO->B_YEL, B_YEL->A_GO
Any other legal pattern SHALL raise code 3.
REQ-019 A dwell counter SHALL be set to 1 on the edge a state is entered, increment while the state holds, and saturate at 255.
REQ-020 Leaving A_YEL or B_YEL with dwell < YEL_MIN SHALL raise code 4.
REQ-021 Remaining in a yellow state until dwell would exceed YEL_MAX SHALL raise code 5.
REQ-022 Fault-code priority on the same edge SHALL be 1 > 2 > 3 > 4 > 5.
- Code 1: either direction does not have exactly one lamp on.
- Code 2: both directions non-red.
REQ-023 On any fault the monitor SHALL enter FAULT, set fault=1 and latch fault_code; later violations SHALL NOT overwrite the code.
REQ-024 In FAULT, flash SHALL be 1 on the entry edge and then toggle every FLASH_HALF cycles; flash SHALL be 0 in all other states.
REQ-025 fault_clr=1 sampled in FAULT SHALL go to INIT and set fault=0, fault_code=0 and flash=0; fault_clr in any other state SHALL be ignored.
REQ-026 cycles SHALL increment on each B_YEL->A_GO transition and wrap from 255 to 0; it SHALL NOT change on fault or fault_clr.

Reset
REQ-027 rst SHALL take priority over fault_clr and all inputs.
REQ-028 After a reset edge: mon_state=INIT, fault=0, fault_code=0, flash=0, cycles=0, dwell=0.
REQ-029 rst asserted mid-phase or in FAULT SHALL give the same result as REQ-028; no violation SHALL be flagged on the reset edge.

Structure
REQ-030 A shared package traffic_pkg SHALL hold:
- the lamp-pattern constants
- the monitor state enum
- the fault-code enum
- the default parameter values
REQ-031 A combinational sub-module signal_pattern_decoder SHALL classify the six lamps into a legal pattern, a one-hot error or a conflict error; the dwell, flash and cycle counters SHALL live in signal_conflict_monitor.

Verification
REQ-032 Reset, then A_GO 5 cycles, A_YEL 3, B_GO 4, B_YEL 3, A_GO -> fault=0 throughout, cycles=1.
REQ-033 In B_GO, drive Ga=1 with Gb held -> after the next edge fault=1, code=2, flash=1, toggling every 4 cycles.
REQ-034 In A_GO, drive Ra=1 and Ga=1 together, with Gb=1 on the same edge -> fault_code=1, not 2 (priority check).
REQ-035 A_YEL held 1 cycle then B_GO -> code 4; a separate run holding A_YEL 9 cycles -> code 5.
REQ-036 In FAULT, pulse fault_clr, then drive A_GO -> INIT then A_GO, fault=0, cycles unchanged; repeat with rst and fault_clr together -> all outputs at reset values.
REQ-037 Run 256 full legal cycles -> cycles wraps to 0.
